// File: rtl/m_cycle_if.sv
// Handshake and operand/result bundle for the m_cycle multiply/divide unit.
interface m_cycle_if #(
  parameter int WIDTH = 4
) ();
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy
  );
endinterface

// File: rtl/m_cycle.sv
// Iterative multiply/divide coprocessor: shift-and-add multiply, restoring
// divide, one bit per cycle on operand magnitudes with sign fix-up at the end.
module m_cycle #(
  parameter int WIDTH = 4
) (
  input  logic      CLK,
  input  logic      RESET,
  m_cycle_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, COMPUTING} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] op1_q;   // raw dividend, returned as remainder on divide by zero
  logic [WIDTH-1:0] dv;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi;      // product high half / partial remainder
  logic [WIDTH-1:0] lo;      // multiplier / dividend shifting into quotient
  logic             qneg, rneg;
  logic [WIDTH-1:0] res1, res2;

  logic             s1, s2, last, ge;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   sum, sh;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] hi_nx, lo_nx, res1_nx, res2_nx;
  logic [2*WIDTH-1:0] prod;

  // Operand signs and magnitudes; unsigned ops (MCycleOp[0]=1) never negate.
  always_comb begin
    s1   = ~bus.MCycleOp[0] & bus.Operand1[WIDTH-1];
    s2   = ~bus.MCycleOp[0] & bus.Operand2[WIDTH-1];
    mag1 = s1 ? -bus.Operand1 : bus.Operand1;
    mag2 = s2 ? -bus.Operand2 : bus.Operand2;
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: start from idle, return after WIDTH iterations.
  always_comb begin
    state_nx = state;
    last     = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE:      if (bus.Start) state_nx = COMPUTING;
      COMPUTING: if (last)      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // One iteration step plus the sign-corrected result of the final step.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
    sh      = {hi, lo[WIDTH-1]};
    ge      = (sh >= {1'b0, dv});
    diff    = sh[WIDTH-1:0] - dv;
    hi_nx   = '0;
    lo_nx   = '0;
    prod    = '0;
    res1_nx = '0;
    res2_nx = '0;
    if (!op_q[1]) begin
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo[WIDTH-1:1]};
      prod  = {hi_nx, lo_nx};
      if (qneg) prod = -prod;
      {res2_nx, res1_nx} = prod;
    end else begin
      hi_nx = ge ? diff : sh[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], ge};
      if (dv == '0) begin
        res1_nx = '1;
        res2_nx = op1_q;
      end else begin
        // most-negative / -1 lands on the most-negative quotient naturally
        res1_nx = qneg ? -lo_nx : lo_nx;
        res2_nx = rneg ? -hi_nx : hi_nx;
      end
    end
  end

  // Datapath: latch operands on start, iterate, write results on the last step.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt   <= '0;
      op_q  <= '0;
      op1_q <= '0;
      dv    <= '0;
      hi    <= '0;
      lo    <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      res1  <= '0;
      res2  <= '0;
    end else if (state == IDLE) begin
      if (bus.Start) begin
        cnt   <= '0;
        op_q  <= bus.MCycleOp;
        op1_q <= bus.Operand1;
        hi    <= '0;
        qneg  <= s1 ^ s2;
        rneg  <= s1;
        dv    <= bus.MCycleOp[1] ? mag2 : mag1;
        lo    <= bus.MCycleOp[1] ? mag1 : mag2;
      end
    end else begin
      cnt <= cnt + CW'(1);
      hi  <= hi_nx;
      lo  <= lo_nx;
      if (last) begin
        res1 <= res1_nx;
        res2 <= res2_nx;
      end
    end
  end

  assign bus.Busy    = (state == COMPUTING);
  assign bus.Result1 = res1;
  assign bus.Result2 = res2;

endmodule

// File: tb/tb_m_cycle.sv
// Self-checking bench for m_cycle (WIDTH=4): directed vectors, randomized ops
// against an integer-arithmetic model, back-to-back handshake, mid-op reset.
module tb_m_cycle;
  localparam int W = 4;

  typedef struct packed {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;  // {Result2, Result1}
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  m_cycle_if #(.WIDTH(W)) bus ();
  m_cycle #(.WIDTH(W)) dut (.CLK(clk), .RESET(rst_n), .bus(bus));

  vec_t mvec [8] = '{
    '{2'b00, 4'hF, 4'hF, 8'h01},
    '{2'b00, 4'h9, 4'h9, 8'h31},
    '{2'b00, 4'hD, 4'h2, 8'hFA},
    '{2'b00, 4'h8, 4'h7, 8'hC8},
    '{2'b00, 4'h7, 4'hA, 8'hD6},
    '{2'b00, 4'h1, 4'h8, 8'hF8},
    '{2'b00, 4'h0, 4'hF, 8'h00},
    '{2'b01, 4'hF, 4'hF, 8'hE1}
  };

  vec_t dvec [11] = '{
    '{2'b10, 4'hC, 4'h3, 8'hFF},
    '{2'b10, 4'hA, 4'hC, 8'hE1},
    '{2'b10, 4'h3, 4'hE, 8'h1F},
    '{2'b10, 4'hC, 4'hC, 8'h01},
    '{2'b10, 4'h0, 4'hE, 8'h00},
    '{2'b10, 4'h8, 4'hF, 8'h08},
    '{2'b10, 4'h9, 4'h0, 8'h9F},
    '{2'b11, 4'h8, 4'h4, 8'h02},
    '{2'b11, 4'h4, 4'h8, 8'h40},
    '{2'b11, 4'h0, 4'h5, 8'h00},
    '{2'b11, 4'h7, 4'h0, 8'h7F}
  };

  // Reference: plain integer arithmetic, returns {Result2, Result1}.
  function automatic logic [2*W-1:0] model(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int ua, ub, sa, sb, p, q, r;
    logic [2*W-1:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    res = '0;
    case (op)
      2'b00: begin p = sa * sb; res = p[2*W-1:0]; end
      2'b01: begin p = ua * ub; res = p[2*W-1:0]; end
      default: begin
        if (ub == 0) begin
          res = {a, {W{1'b1}}};
        end else begin
          if (op == 2'b10) begin
            if (sa == -(1 << (W-1)) && sb == -1) begin q = sa; r = 0; end
            else begin q = sa / sb; r = sa % sb; end
          end else begin
            q = ua / ub; r = ua % ub;
          end
          res = {r[W-1:0], q[W-1:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Runs one operation, scrambling inputs while busy; returns results and busy length.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] res, output int busy_cycles);
    @(negedge clk);
    bus.Start = 1'b1; bus.MCycleOp = op; bus.Operand1 = a; bus.Operand2 = b;
    @(negedge clk);
    bus.Start = 1'b0;
    busy_cycles = 0;
    while (bus.Busy === 1'b1 && busy_cycles < 20) begin
      busy_cycles++;
      bus.Operand1 = W'($urandom);
      bus.Operand2 = W'($urandom);
      bus.MCycleOp = 2'($urandom);
      @(negedge clk);
    end
    res = {bus.Result2, bus.Result1};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.MCycleOp = '0; bus.Operand1 = '0; bus.Operand2 = '0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({bus.Busy, bus.Result2, bus.Result1} !== '0) begin
      $display("FAIL reset_state: got busy=%b r2=%h r1=%h want all 0",
               bus.Busy, bus.Result2, bus.Result1);
    end else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed_mul();
    logic [2*W-1:0] res;
    int bc;
    for (int i = 0; i < 8; i++) begin
      do_op(mvec[i].op, mvec[i].a, mvec[i].b, res, bc);
      total_cnt++;
      if (res !== mvec[i].exp)
        $display("FAIL mul_%0d: op=%b %h*%h got %h want %h", i, mvec[i].op, mvec[i].a, mvec[i].b, res, mvec[i].exp);
      else pass_cnt++;
      total_cnt++;
      if (bc !== W) $display("FAIL mul_busy_%0d: got %0d cycles want %0d", i, bc, W);
      else pass_cnt++;
    end
  endtask

  task automatic test_directed_div();
    logic [2*W-1:0] res;
    int bc;
    for (int i = 0; i < 11; i++) begin
      do_op(dvec[i].op, dvec[i].a, dvec[i].b, res, bc);
      total_cnt++;
      if (res !== dvec[i].exp)
        $display("FAIL div_%0d: op=%b %h/%h got %h want %h", i, dvec[i].op, dvec[i].a, dvec[i].b, res, dvec[i].exp);
      else pass_cnt++;
      total_cnt++;
      if (bc !== W) $display("FAIL div_busy_%0d: got %0d cycles want %0d", i, bc, W);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [2*W-1:0] res, exp;
    logic [1:0] op;
    logic [W-1:0] a, b;
    int bc;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); a = W'($urandom); b = W'($urandom);
      exp = model(op, a, b);
      do_op(op, a, b, res, bc);
      total_cnt++;
      if (res !== exp)
        $display("FAIL rand_%0d: op=%b a=%h b=%h got %h want %h", i, op, a, b, res, exp);
      else pass_cnt++;
      total_cnt++;
      if (bc !== W) $display("FAIL rand_busy_%0d: got %0d cycles want %0d", i, bc, W);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] pop;
    logic [W-1:0] pa, pb;
    logic [2*W-1:0] pexp;
    logic exp_busy;
    @(negedge clk);
    pop = 2'($urandom); pa = W'($urandom); pb = W'($urandom);
    pexp = model(pop, pa, pb);
    bus.Start = 1'b1; bus.MCycleOp = pop; bus.Operand1 = pa; bus.Operand2 = pb;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      exp_busy = (k % 5 != 0);
      total_cnt++;
      if (bus.Busy !== exp_busy) $display("FAIL b2b_busy_%0d: got %b want %b", k, bus.Busy, exp_busy);
      else pass_cnt++;
      if (!exp_busy) begin
        total_cnt++;
        if ({bus.Result2, bus.Result1} !== pexp)
          $display("FAIL b2b_res_%0d: got %h want %h", k, {bus.Result2, bus.Result1}, pexp);
        else pass_cnt++;
        if (k == 15) begin
          bus.Start = 1'b0;
        end else begin
          pop = 2'($urandom); pa = W'($urandom); pb = W'($urandom);
          pexp = model(pop, pa, pb);
          bus.MCycleOp = pop; bus.Operand1 = pa; bus.Operand2 = pb;
        end
      end else begin
        bus.MCycleOp = 2'($urandom); bus.Operand1 = W'($urandom); bus.Operand2 = W'($urandom);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] res;
    int bc;
    do_op(2'b00, 4'h9, 4'h9, res, bc);
    total_cnt++;
    if (res !== 8'h31) $display("FAIL rst_pre: got %h want 31", res);
    else pass_cnt++;
    @(negedge clk);
    bus.Start = 1'b1; bus.MCycleOp = 2'b01; bus.Operand1 = 4'h5; bus.Operand2 = 4'h3;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.Busy, bus.Result2, bus.Result1} !== '0)
      $display("FAIL rst_mid: got busy=%b r2=%h r1=%h want all 0", bus.Busy, bus.Result2, bus.Result1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.Busy, bus.Result2, bus.Result1} !== '0)
      $display("FAIL rst_hold: got busy=%b r2=%h r1=%h want all 0", bus.Busy, bus.Result2, bus.Result1);
    else pass_cnt++;
    rst_n = 1'b1;
    do_op(2'b11, 4'hE, 4'h3, res, bc);
    total_cnt++;
    if (res !== 8'h24) $display("FAIL rst_after: got %h want 24", res);
    else pass_cnt++;
    total_cnt++;
    if (bc !== W) $display("FAIL rst_after_busy: got %0d cycles want %0d", bc, W);
    else pass_cnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed_mul();
    test_directed_div();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
